decoder_proj: RTL and testbench



---
 rtl/decoder_proj.sv | 74 +++++++
 tb/tb_decoder_proj.sv | 119 +++++++++++
 2 files changed

// File: rtl/decoder_proj.sv
// Registered hex-digit / one-hot decoder in the 7-in / 8-out pad frame.
// Clock, reset, code and mode all arrive on io_in.
module decoder_proj (
    input  logic [6:0] io_in,
    output logic [7:0] io_out
);

    logic       clock;
    logic       reset;
    logic [3:0] code;
    logic       mode;

    assign clock = io_in[0];
    assign reset = io_in[1];
    assign code  = io_in[5:2];
    assign mode  = io_in[6];

    logic [6:0] seg;
    logic       hex_digit;
    logic [7:0] seg_word;
    logic [7:0] onehot_word;
    logic [7:0] decoded;

    // Active-high segments, a in bit 0 through g in bit 6.
    always_comb begin
        seg = 7'h00;
        unique case (code)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

    assign hex_digit = code[3] & (code[2] | code[1]);
    assign seg_word  = {hex_digit, seg};

    always_comb begin
        onehot_word = 8'h00;
        if (code[3]) begin
            onehot_word = 8'h01 << code[2:0];
        end
    end

    always_comb begin
        decoded = 8'h00;
        unique case (1'b1)
            mode:  decoded = onehot_word;
            !mode: decoded = seg_word;
        endcase
    end

    // Single output register; reset wins over decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_out <= 8'h00;
        end else begin
            io_out <= decoded;
        end
    end

endmodule

// File: tb/tb_decoder_proj.sv
// Scoreboard bench for decoder_proj.
// Expected words are queued at drive time and popped after each edge.
module tb_decoder_proj;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [3:0] code;
    logic [6:0] io_in;
    logic [7:0] io_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    logic [7:0] last_exp;
    logic       have_last = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    assign io_in = {mode, code, rst, clk};

    decoder_proj dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic r,
                                         input logic m,
                                         input logic [3:0] c);
        logic [7:0] w;
        if (r) begin
            w = 8'h00;
        end else if (m) begin
            w = c[3] ? (8'h01 << c[2:0]) : 8'h00;
        end else begin
            w = {(c >= 4'hA), seg_tab[c]};
        end
        return w;
    endfunction

    task automatic step(input string tag,
                        input logic r,
                        input logic m,
                        input logic [3:0] c);
        logic [7:0] exp;
        @(negedge clk);
        rst  = r;
        mode = m;
        code = c;
        sb.push_back(model(r, m, c));
        #1;
        if (have_last) check({tag, "_hold"}, io_out, last_exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, io_out, 8'hxx);
        end else begin
            exp = sb.pop_front();
            check(tag, io_out, exp);
            last_exp  = exp;
            have_last = 1'b1;
        end
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b1;
        code = 4'hF;

        step("rst0", 1'b1, 1'b1, 4'hF);
        step("rst1", 1'b1, 1'b1, 4'hF);
        step("rel3", 1'b0, 1'b0, 4'h3);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("seg%0h", i), 1'b0, 1'b0, 4'(i));
        end

        for (int i = 0; i < 16; i++) begin
            step($sformatf("oh%0h", i), 1'b0, 1'b1, 4'(i));
        end

        step("cover", 1'b0, 1'b1, 4'hE);
        if (last_exp !== 8'h40) check("cover_tab", last_exp, 8'h40);

        for (int i = 0; i < 6; i++) begin
            step($sformatf("tog%0d", i), 1'b0, i[0], 4'hA);
        end

        step("mid7", 1'b0, 1'b0, 4'h7);
        step("midrst", 1'b1, 1'b0, 4'h8);
        step("mid8", 1'b0, 1'b0, 4'h8);

        for (int i = 0; i < 20; i++) begin
            step("rand", ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
